// File: rtl/uart_pkg.sv
// Shared UART receive definitions: controller FSM encoding, config word
// field positions and the data-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RUN     = 2'd1,
    ST_QUIESCE = 2'd2,
    ST_APPLY   = 2'd3
  } rx_state_e;

  // config word layout: {data[1:0], stop[1:0], parity_en}
  localparam int PARITY_EN_BIT     = 0;
  localparam int STOP_LSB          = 1;
  localparam int DATA_LSB          = 3;
  localparam int DATA_W_BASE       = 5;
  localparam int DEF_TIMEOUT_TICKS = 640;

  // number of data bits encoded by the config data field
  function automatic int data_width(input logic [1:0] fld);
    return DATA_W_BASE + int'(fld);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words. Head is read combinationally
// and reads as zero when empty; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem[rd_ptr];

  // storage write; cleared on reset so the head never reads X
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  // pointers wrap naturally (power-of-two depth); level tracks occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_o <= level_o + 1'b1;
        2'b01:   level_o <= level_o - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates rx_module, applies configuration only
// while the line is quiet, captures finished frames into a FIFO.
// Optional idle timeout built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int MAX_UART_DATA_W  = 8,
  parameter int TOTAL_CONF_WIDTH = 5,
  parameter int FIFO_DEPTH       = 8,
  parameter int TIMEOUT_TICKS    = DEF_TIMEOUT_TICKS
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         baud_en_i,
  input  logic                         enable_i,
  input  logic                         cfg_valid_i,
  input  logic [TOTAL_CONF_WIDTH-1:0]  cfg_i,
  output logic                         cfg_ready_o,
  output logic                         rx_en_o,
  output logic [TOTAL_CONF_WIDTH-1:0]  rx_conf_o,
  input  logic                         rx_done_i,
  input  logic                         rx_busy_i,
  input  logic                         rx_parity_err_i,
  input  logic [MAX_UART_DATA_W-1:0]   rx_data_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [MAX_UART_DATA_W-1:0]   rd_data_o,
  output logic                         rd_perr_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic                         overrun_o,
  input  logic                         ovr_clr_i,
  output logic                         timeout_o
);

  rx_state_e                     state, nstate;
  logic                          pend;
  logic [TOTAL_CONF_WIDTH-1:0]   cfg_buf;
  logic                          done_q;
  logic                          hs, push_req, pop, full, empty, ovr_set;
  logic [MAX_UART_DATA_W-1:0]    mask;

  assign hs          = cfg_valid_i & cfg_ready_o;
  assign cfg_ready_o = ((state == ST_OFF) || (state == ST_RUN)) && !pend;
  assign rx_en_o     = (state == ST_RUN);
  assign push_req    = rx_done_i & ~done_q;
  assign pop         = rd_valid_o & rd_ready_i;
  assign rd_valid_o  = ~empty;
  assign ovr_set     = push_req & full & ~pop;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_OFF;
    else         state <= nstate;
  end

  // FSM next state; Quiesce holds until rx_module is idle and done is low
  always_comb begin
    nstate = state;
    case (state)
      ST_OFF:     if (enable_i) nstate = ST_RUN;
      ST_RUN:     if (!enable_i || hs) nstate = ST_QUIESCE;
      ST_QUIESCE: if (!rx_busy_i && !rx_done_i) nstate = pend ? ST_APPLY : ST_OFF;
      ST_APPLY:   nstate = enable_i ? ST_RUN : ST_OFF;
      default:    nstate = ST_OFF;
    endcase
  end

  // config: direct update in Off, deferred through cfg_buf while running;
  // the deferred copy lands on entry to Apply, when rx_module is idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_conf_o <= '0;
      cfg_buf   <= '0;
      pend      <= 1'b0;
    end else if ((state == ST_OFF) && hs) begin
      rx_conf_o <= cfg_i;
    end else if ((state == ST_RUN) && hs) begin
      cfg_buf <= cfg_i;
      pend    <= 1'b1;
    end else if ((state == ST_QUIESCE) && (nstate == ST_APPLY)) begin
      rx_conf_o <= cfg_buf;
      pend      <= 1'b0;
    end
  end

  // rx_done edge register, active in every state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) done_q <= 1'b0;
    else         done_q <= rx_done_i;
  end

  // keep only the configured number of data bits
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_UART_DATA_W; i++)
      mask[i] = (i < data_width(rx_conf_o[DATA_LSB +: 2]));
  end

  uart_rx_fifo #(
    .WIDTH (MAX_UART_DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i ({rx_parity_err_i, rx_data_i & mask}),
    .rdata_o ({rd_perr_o, rd_data_o}),
    .level_o (fifo_level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // sticky overrun; a new drop beats a clear in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        overrun_o <= 1'b0;
    else if (ovr_set)   overrun_o <= 1'b1;
    else if (ovr_clr_i) overrun_o <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt;
  logic          push_ok;

  assign push_ok   = push_req & (~full | pop);
  assign timeout_o = (tcnt == TW'(TIMEOUT_TICKS));

  // idle counter: counts ticks with unread data and a quiet line, saturating
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      tcnt <= '0;
    else if (push_ok || pop || (state == ST_OFF))
      tcnt <= '0;
    else if (baud_en_i && !empty && !rx_busy_i && !timeout_o)
      tcnt <= tcnt + 1'b1;
  end
`else
  logic unused_baud;
  assign unused_baud = baud_en_i;
  assign timeout_o   = 1'b0;
`endif

endmodule
